// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and default sizes for the register-file port arbiter.
package regfile_port_arbiter_pkg;

  localparam int unsigned RF_AW    = 3;
  localparam int unsigned RF_DW    = 32;
  localparam int unsigned RF_DEPTH = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StRdWait = 2'd2,
    StResp   = 2'd3
  } state_e;

  // Request payload at the default register-file geometry.
  typedef struct packed {
    logic             we;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] wdata;
  } req_payload_t;

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from i_last+1 (mod NUM_REQ) upwards.
module rr_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  logic [IW-1:0] w_cand;

  // First requester found after the previous winner takes the grant.
  always_comb begin
    o_gnt_oh = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_cand   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IW'((32'(i_last) + k) % NUM_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_gnt_oh[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single register-file port, one access at a time.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned AW      = RF_AW,
  parameter int unsigned DW      = RF_DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rf_en,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_addr,
  output logic [DW-1:0]         rf_wdata,
  input  logic [DW-1:0]         rf_rdata,
  output logic                  busy
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             r_state, w_state_nxt;
  logic [IW-1:0]      r_last;
  logic [NUM_REQ-1:0] r_win_oh;
  logic               r_we;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_wdata;
  logic [DW-1:0]      r_rdata;

  logic [NUM_REQ-1:0] w_win_oh;
  logic [IW-1:0]      w_win_idx;
  logic               w_win_valid;
  logic               w_accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .i_req    (req),
    .i_last   (r_last),
    .o_gnt_oh (w_win_oh),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  assign w_accept = (r_state == StIdle) && w_win_valid;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: writes finish after ISSUE, reads go through RD_WAIT and RESP.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_win_valid) w_state_nxt = StIssue;
      StIssue:  w_state_nxt = r_we ? StIdle : StRdWait;
      StRdWait: w_state_nxt = StResp;
      StResp:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Latch winner and payload on accept; capture read data in RD_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= IW'(NUM_REQ - 1);
      r_win_oh <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_last   <= w_win_idx;
        r_win_oh <= w_win_oh;
        r_we     <= req_we[w_win_idx];
        r_addr   <= req_addr[w_win_idx*AW +: AW];
        r_wdata  <= req_wdata[w_win_idx*DW +: DW];
      end
      if (r_state == StRdWait) begin
        r_rdata <= rf_rdata;
      end
    end
  end

  // Outputs are pure state decodes, so reset zeroes them immediately.
  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rf_en     = 1'b0;
    rf_we     = 1'b0;
    rf_addr   = '0;
    rf_wdata  = '0;
    busy      = (r_state != StIdle);
    unique case (r_state)
      StIssue: begin
        gnt      = r_win_oh;
        rf_en    = 1'b1;
        rf_we    = r_we;
        rf_addr  = r_addr;
        rf_wdata = r_wdata;
      end
      StResp: begin
        rsp_valid = r_win_oh;
        rsp_rdata = r_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench with a transaction-level model checked every cycle.
module tb_regfile_port_arbiter;
  import regfile_port_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 3;
  localparam int DW = 32;

  logic            clk, rst_n;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, rsp_valid;
  logic [DW-1:0]   rsp_rdata, rf_wdata, rf_rdata;
  logic            rf_en, rf_we, busy;
  logic [AW-1:0]   rf_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gnt_log[$];
  int rsp_count = 0;
  logic [N-1:0] rearm = '0;
  logic [N-1:0] pend  = '0;

  regfile_port_arbiter #(
    .NUM_REQ (N),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rf_en     (rf_en),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file with registered read data.
  logic [DW-1:0] rf_mem [8];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
      rf_rdata <= '0;
    end else if (rf_en) begin
      if (rf_we) rf_mem[rf_addr] <= rf_wdata;
      else       rf_rdata <= rf_mem[rf_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an accepted op occupies age 1 (grant) .. age 1 for writes, age 3 for reads.
  initial begin : compare
    bit            m_active;
    int            m_age, m_win, m_last, m_addr, idx;
    bit            m_we, found;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_mem [8];
    logic [N-1:0]  e_gnt, e_rsp;
    logic          e_en, e_we;
    m_active = 0; m_age = 0; m_win = 0; m_last = N - 1; m_addr = 0; m_we = 0; m_wdata = '0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
      if (|rsp_valid) rsp_count++;
      if (!rst_n) begin
        chk("reset_ctrl", 64'({gnt, rsp_valid, rf_en, rf_we, busy}), 64'd0);
        chk("reset_data", 64'({rsp_rdata, rf_wdata}), 64'd0);
        chk("reset_addr", 64'(rf_addr), 64'd0);
        m_active = 0;
        m_last = N - 1;
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
      end else begin
        e_gnt = '0; e_rsp = '0; e_en = 1'b0; e_we = 1'b0;
        if (m_active && m_age == 1) begin
          e_gnt = N'(1) << m_win;
          e_en  = 1'b1;
          e_we  = m_we;
        end
        if (m_active && !m_we && m_age == 3) e_rsp = N'(1) << m_win;
        chk("m_gnt", 64'(gnt), 64'(e_gnt));
        chk("m_rf_en", 64'(rf_en), 64'(e_en));
        chk("m_rf_we", 64'(rf_we), 64'(e_we));
        chk("m_rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        chk("m_busy", 64'(busy), 64'(m_active));
        if (e_en) begin
          chk("m_rf_addr", 64'(rf_addr), 64'(m_addr));
          chk("m_rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        end
        if (e_rsp != 0) chk("m_rsp_rdata", 64'(rsp_rdata), 64'(m_mem[m_addr]));
        // Advance the model to the next cycle.
        if (m_active) begin
          if (m_we && m_age == 1) m_mem[m_addr] = m_wdata;
          if ((m_we && m_age == 1) || (!m_we && m_age == 3)) m_active = 0;
          else m_age++;
        end else if (req != 0) begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && req[idx]) begin
              found = 1;
              m_win = idx;
            end
          end
          m_last   = m_win;
          m_active = 1;
          m_age    = 1;
          m_we     = req_we[m_win];
          m_addr   = int'(req_addr[m_win*AW +: AW]);
          m_wdata  = req_wdata[m_win*DW +: DW];
        end
      end
    end
  end

  // One clock; requesters drop req the cycle after their grant, optionally re-raising later.
  task automatic cycle();
    logic [N-1:0] g;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        req[i]  = 1'b1;
        pend[i] = 1'b0;
      end
      if (g[i]) begin
        req[i] = 1'b0;
        if (rearm[i]) pend[i] = 1'b1;
      end
    end
  endtask

  task automatic set_req(input int i, input req_payload_t p);
    req[i]                = 1'b1;
    req_we[i]             = p.we;
    req_addr[i*AW +: AW]  = p.addr;
    req_wdata[i*DW +: DW] = p.wdata;
  endtask

  initial begin : stim
    int base, n, cnt;
    int exp_seq [6];
    exp_seq = '{0, 1, 2, 0, 1, 2};
    rst_n = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Single write.
    set_req(1, '{we: 1'b1, addr: 3'd5, wdata: 32'hDEADBEEF});
    cycle();
    chk("t1_gnt", 64'(gnt), 64'b010);
    chk("t1_rf_en_we", 64'({rf_en, rf_we}), 64'b11);
    chk("t1_rf_addr", 64'(rf_addr), 64'd5);
    chk("t1_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    cycle();
    chk("t1_busy_c2", 64'(busy), 64'd0);

    // Read after write.
    set_req(0, '{we: 1'b1, addr: 3'd3, wdata: 32'h12345678});
    cycle();
    chk("t2_wgnt", 64'(gnt), 64'b001);
    cycle();
    set_req(2, '{we: 1'b0, addr: 3'd3, wdata: 32'h0});
    cycle();
    chk("t2_rgnt", 64'(gnt), 64'b100);
    cycle();
    cycle();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'b100);
    chk("t2_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
    cycle();
    chk("t2_busy_end", 64'(busy), 64'd0);

    // Fairness under continuous requests.
    base = gnt_log.size();
    rearm = '1;
    for (int i = 0; i < N; i++)
      set_req(i, '{we: 1'b1, addr: 3'(4 + i), wdata: 32'hF000_0000 + 32'(i)});
    n = 0;
    while (gnt_log.size() < base + 6 && n < 40) begin
      cycle();
      n++;
    end
    req = '0; rearm = '0; pend = '0;
    chk("t3_six_grants", 64'(gnt_log.size() >= base + 6), 64'd1);
    for (int k = 0; k < 6; k++)
      if (base + k < gnt_log.size()) chk("t3_order", 64'(gnt_log[base + k]), 64'(exp_seq[k]));
    cycle();
    cycle();

    // Busy blocking.
    set_req(0, '{we: 1'b0, addr: 3'd4, wdata: 32'h0});
    cycle();
    chk("t4_gnt0", 64'(gnt), 64'b001);
    cycle();
    set_req(1, '{we: 1'b1, addr: 3'd6, wdata: 32'hA5A5A5A5});
    cycle();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'b001);
    chk("t4_rsp_rdata", 64'(rsp_rdata), 64'hF0000000);
    chk("t4_blocked_resp", 64'(gnt), 64'd0);
    cycle();
    chk("t4_idle_busy", 64'(busy), 64'd0);
    chk("t4_blocked_idle", 64'(gnt), 64'd0);
    cycle();
    chk("t4_gnt1", 64'(gnt), 64'b010);
    cycle();

    // Reset in the middle of a read.
    set_req(0, '{we: 1'b0, addr: 3'd6, wdata: 32'h0});
    cycle();
    chk("t5_gnt0", 64'(gnt), 64'b001);
    cycle();
    chk("t5_in_rdwait", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctrl", 64'({gnt, rsp_valid, rf_en, rf_we, busy}), 64'd0);
    chk("t5_rst_rdata", 64'(rsp_rdata), 64'd0);
    cnt = rsp_count;
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("t5_no_rsp", 64'(rsp_count), 64'(cnt));
    set_req(0, '{we: 1'b1, addr: 3'd1, wdata: 32'h11});
    set_req(1, '{we: 1'b1, addr: 3'd2, wdata: 32'h22});
    cycle();
    chk("t5_first_gnt", 64'(gnt), 64'b001);
    cycle();
    cycle();
    chk("t5_second_gnt", 64'(gnt), 64'b010);
    cycle();

    // Withdrawal after one cycle; later payload changes are ignored.
    set_req(2, '{we: 1'b0, addr: 3'd1, wdata: 32'h0});
    cycle();
    req[2] = 1'b0;
    req_addr[2*AW +: AW] = 3'd7;
    chk("t6_gnt2", 64'(gnt), 64'b100);
    chk("t6_rf_addr", 64'(rf_addr), 64'd1);
    cycle();
    cycle();
    chk("t6_rsp_valid", 64'(rsp_valid), 64'b100);
    chk("t6_rsp_rdata", 64'(rsp_rdata), 64'h11);
    cycle();
    chk("t6_busy_end", 64'(busy), 64'd0);

    repeat (2) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 3, number of requesters; AW, default 3, register address width (8 registers); DW, default 32, register data width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*AW  packed addresses; requester i at bits [i*AW +: AW].
- req_wdata  in  NUM_REQ*DW  packed write data; requester i at bits [i*DW +: DW].
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse.
- rsp_rdata  out  DW  read data, meaningful only while any rsp_valid bit is 1.
- rf_en  out  1  register file port enable.
- rf_we  out  1  register file write enable.
- rf_addr  out  AW  register file address.
- rf_wdata  out  DW  register file write data.
- rf_rdata  in  DW  register file registered read data, valid one cycle after the rf_en read cycle.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, RD_WAIT and RESP.
REQ-004 In IDLE, if any req bit is 1, the block SHALL latch the round-robin winner index, its we, addr and wdata, then move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: the search starts at last_winner+1 modulo NUM_REQ; after reset last_winner = NUM_REQ-1, so requester 0 has first priority.
REQ-006 In ISSUE, the block SHALL assert gnt[winner], rf_en = 1, rf_we = latched we, rf_addr = latched addr and rf_wdata = latched wdata for exactly one cycle.
REQ-007 From ISSUE, a write SHALL go to IDLE and a read SHALL go to RD_WAIT.
REQ-008 In RD_WAIT, the block SHALL capture rf_rdata into the response register, then move to RESP.
REQ-009 In RESP, the block SHALL assert rsp_valid[winner] for one cycle with rsp_rdata = the captured value, then return to IDLE.
REQ-010 Latency SHALL be as follows, with cycle 0 = req seen in IDLE:
- write: gnt in cycle 1; busy drops in cycle 2.
- read: gnt in cycle 1; rsp_valid in cycle 3; IDLE again in cycle 4.
REQ-011 Outside ISSUE, rf_en, rf_we and gnt SHALL be 0; outside RESP, rsp_valid SHALL be 0.
REQ-012 Requests arriving while busy = 1 SHALL be ignored until IDLE and SHALL NOT be lost as long as the requester keeps req high.
REQ-013 A requester SHALL hold req, req_we, req_addr and req_wdata stable until it sees gnt, and SHALL drop req in the cycle after gnt. If req is still high in IDLE, it SHALL be treated as a new request.
REQ-014 Once latched, a request SHALL complete even if req is withdrawn; payload changes after latching SHALL have no effect.
REQ-015 The block SHALL update last_winner only on the IDLE-to-ISSUE transition.
REQ-016 When all requesters request continuously, each SHALL be granted once in every NUM_REQ grants.

Reset
REQ-017 Asserting rst_n low SHALL asynchronously force IDLE, last_winner = NUM_REQ-1 and all latched fields to 0.
REQ-018 During reset, every output SHALL be 0: gnt, rsp_valid, rsp_rdata, rf_en, rf_we, rf_addr, rf_wdata and busy.
REQ-019 A reset during ISSUE, RD_WAIT or RESP SHALL abort the operation. No rsp_valid SHALL follow, and an rf_en pulse SHALL never be truncated to a glitch beyond the reset edge.
REQ-020 The first grant SHALL be possible in the second posedge after rst_n deasserts.

Structure
REQ-021 A shared package SHALL hold: the FSM state enum (2 bits); default constants RF_AW = 3, RF_DW = 32 and RF_DEPTH = 8; and a request-payload struct {we, addr, wdata}.
REQ-022 The block SHALL contain one sub-module, rr_arbiter, which computes combinationally a one-hot winner and winner index from req and last_winner. The FSM and datapath registers SHALL stay in regfile_port_arbiter.

Verification
REQ-023 Single write: req[1] = 1, we = 1, addr = 5, wdata = 32'hDEADBEEF -> gnt[1] in cycle 1 with rf_en = 1, rf_we = 1, rf_addr = 5, rf_wdata = DEADBEEF; busy = 0 in cycle 2.
REQ-024 Read-after-write: write 32'h12345678 to reg 3 via requester 0, then read reg 3 via requester 2 -> rsp_valid[2] 2 cycles after gnt[2], with rsp_rdata = 32'h12345678.
REQ-025 Fairness: req = 3'b111 held, each requester dropping req only for the cycle after its grant -> gnt sequence 0, 1, 2, 0, 1, 2; no requester granted twice in 3 grants.
REQ-026 Busy blocking: req[0] read in progress, req[1] asserted in RD_WAIT -> gnt[1] only after RESP, in the cycle after the next IDLE.
REQ-027 Reset mid-read: rst_n low in RD_WAIT for 1 cycle -> all outputs 0 immediately, no rsp_valid afterwards, and the next req[0] is granted first.
REQ-028 Withdrawal: req[2] pulsed for 1 cycle in IDLE -> the operation still completes, with gnt[2] in cycle 1.
